best_sad_tracker: RTL

//   Downstream of the 16-PE instant minimum comparator. Consumes one masked-valid
//   min-SAD per cycle over a full search, one per candidate group.

---
 rtl/best_sad_tracker.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/best_sad_tracker.sv
// Tracks the running minimum SAD and its group index across one motion search.
// Publishes the result with a one-cycle done pulse once the last group is sampled.
module best_sad_tracker #(
  parameter int MAX_DATA_WIDTH  = 16,
  parameter int NUM_GROUPS      = 16,
  parameter int GROUP_IDX_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [MAX_DATA_WIDTH-1:0]  in_min_SAD,
  input  logic                       in_SAD_valid,
  output logic                       busy,
  output logic                       done,
  output logic                       out_valid,
  output logic [MAX_DATA_WIDTH-1:0]  out_best_SAD,
  output logic [GROUP_IDX_WIDTH-1:0] out_best_idx
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [MAX_DATA_WIDTH-1:0]  SAD_ONES = {MAX_DATA_WIDTH{1'b1}};
  localparam logic [GROUP_IDX_WIDTH-1:0] IDX_ZERO = {GROUP_IDX_WIDTH{1'b0}};
  localparam logic [GROUP_IDX_WIDTH-1:0] IDX_ONE  = {{(GROUP_IDX_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [GROUP_IDX_WIDTH-1:0] LAST_IDX = GROUP_IDX_WIDTH'(NUM_GROUPS - 1);

  state_t                       r_state;
  state_t                       w_state_next;
  logic [GROUP_IDX_WIDTH-1:0]   r_cnt;
  logic [MAX_DATA_WIDTH-1:0]    r_best;
  logic [GROUP_IDX_WIDTH-1:0]   r_best_idx;

  logic                         w_accept_start;
  logic                         w_sample;
  logic                         w_last;
  logic                         w_take;
  logic [MAX_DATA_WIDTH-1:0]    w_best_fwd;
  logic [GROUP_IDX_WIDTH-1:0]   w_idx_fwd;

  logic                         w_busy_next;
  logic                         w_done_next;
  logic                         w_out_valid_next;
  logic [MAX_DATA_WIDTH-1:0]    w_out_best_sad_next;
  logic [GROUP_IDX_WIDTH-1:0]   w_out_best_idx_next;

  // Sample qualification and strict-less-than compare; ties keep the earlier group.
  always_comb begin
    w_accept_start = (r_state == ST_IDLE) && start;
    w_sample       = (r_state == ST_SEARCH) && in_SAD_valid;
    w_last         = w_sample && (r_cnt == LAST_IDX);
    w_take         = w_sample && (in_min_SAD < r_best);
    if (w_take) begin
      w_best_fwd = in_min_SAD;
      w_idx_fwd  = r_cnt;
    end else begin
      w_best_fwd = r_best;
      w_idx_fwd  = r_best_idx;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_SEARCH;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_SEARCH: begin
        if (w_last) begin
          w_state_next = ST_DONE;
        end else begin
          w_state_next = ST_SEARCH;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Running minimum and group counter; counter holds on the final sample instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= IDX_ZERO;
      r_best     <= SAD_ONES;
      r_best_idx <= IDX_ZERO;
    end else if (w_accept_start) begin
      r_cnt      <= IDX_ZERO;
      r_best     <= SAD_ONES;
      r_best_idx <= IDX_ZERO;
    end else if (w_sample) begin
      if (w_last) begin
        r_cnt <= r_cnt;
      end else begin
        r_cnt <= r_cnt + IDX_ONE;
      end
      r_best     <= w_best_fwd;
      r_best_idx <= w_idx_fwd;
    end else begin
      r_cnt      <= r_cnt;
      r_best     <= r_best;
      r_best_idx <= r_best_idx;
    end
  end

  // FSM output logic: next values of the registered outputs, with last-sample forwarding.
  always_comb begin
    w_busy_next = (w_state_next != ST_IDLE);
    w_done_next = (w_state_next == ST_DONE);
    if (w_accept_start) begin
      w_out_valid_next = 1'b0;
    end else if (w_done_next) begin
      w_out_valid_next = 1'b1;
    end else begin
      w_out_valid_next = out_valid;
    end
    if (w_done_next) begin
      w_out_best_sad_next = w_best_fwd;
      w_out_best_idx_next = w_idx_fwd;
    end else begin
      w_out_best_sad_next = out_best_SAD;
      w_out_best_idx_next = out_best_idx;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      out_valid    <= 1'b0;
      out_best_SAD <= {MAX_DATA_WIDTH{1'b0}};
      out_best_idx <= IDX_ZERO;
    end else begin
      busy         <= w_busy_next;
      done         <= w_done_next;
      out_valid    <= w_out_valid_next;
      out_best_SAD <= w_out_best_sad_next;
      out_best_idx <= w_out_best_idx_next;
    end
  end

endmodule
